pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Duty-cycle sequencer for the PWM datapath. It accepts a target duty and a step size over a valid/ready handshake. It then ramps its `duty` output toward the target by one step per ramp tick, using an internal prescaler derived from the 50 MHz system clock. It sits between the board-level command logic and the PWM comparator and replaces direct, jumpy duty writes.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency, Hz.
- `STEP_FREQ`, 1000: ramp tick rate, Hz. `TICK_MAX = CLK_FREQ/STEP_FREQ` must be ≥ 2.
- `DUTY_W`, 8: duty / target / step width.

- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: controller idle; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_target`, in, DUTY_W: target duty.
- `cmd_step`, in, DUTY_W: increment per tick. A value of 0 is treated as 1.
- `abort`, in, 1: stop the ramp and hold the current duty.
- `duty`, out, DUTY_W: duty value to the PWM datapath.
- `busy`, out, 1: ramp in progress.
- `done`, out, 1: one-cycle pulse when `duty` reaches target.

## Operation
- FSM states are IDLE, RAMP and DONE.
  - IDLE: `cmd_ready=1`. On accept, latch target and step (0→1), clear the prescaler, and go to RAMP.
  - RAMP: the prescaler counts 0..TICK_MAX-1. At count TICK_MAX-1 it returns to 0 and a tick occurs.
  - On a tick with duty<target: duty ← min(duty+step, target).
  - On a tick with duty>target: duty ← max(duty−step, target).
  - Arithmetic for both updates is in DUTY_W+1 bits, so there is no wrap at 2^DUTY_W−1 or below 0.
  - If the updated duty equals target, go to DONE.
  - If target equals duty at accept, RAMP goes to DONE on its first cycle with no tick and no duty change.
  - DONE: `done=1` for exactly one cycle, then IDLE.
- `abort` while in RAMP: go to IDLE on that edge. `duty` holds its value, no `done` pulse, prescaler cleared. `abort` has priority over a same-cycle tick, so no duty update occurs.
- `abort` in IDLE or DONE is ignored; a DONE pulse still completes.
- Commands offered while not in IDLE are not accepted. `cmd_valid` may stay high and is accepted on return to IDLE.
- Outputs:
  - `busy = (state==RAMP)`.
  - `cmd_ready = (state==IDLE)`.
  - `done = (state==DONE)`.
  - `duty` is a register, updated only in RAMP on ticks.
- Reset (`rst=0`, asynchronous): state IDLE, duty 0, prescaler 0, latched target/step 0. `cmd_ready` goes to 1 and `busy`/`done` to 0 immediately. Reset mid-ramp aborts the ramp and forces duty to 0.

## Timing
- Accept at edge E0. The first duty update is at edge E0+TICK_MAX, and subsequent updates every TICK_MAX cycles.
- Final update at edge Ef. `done` is high during cycle Ef..Ef+1, and `cmd_ready` returns at edge Ef+1.
- Equal target at accept: RAMP for 1 cycle, then DONE. `done` is high 2 cycles after accept.
- Ramp length is ceil(|target−duty| / step) ticks.
- Back-to-back commands: the minimum spacing between accepts is update count × TICK_MAX + 2 cycles.
- No combinational path exists from any input to any output.

## Structure
- Package `pwm_pkg` holds:
  - the state enum (IDLE, RAMP, DONE);
  - the `CLK_FREQ` default;
  - a `TICK_MAX` computation function;
  - a `clog2`-based prescaler width constant.
- Sub-module `tick_gen` is the prescaler.
  - Inputs: `clk`, `rst` (active-low asynchronous), `clr`, `en`.
  - Output: `tick`, one cycle, asserted when count==TICK_MAX-1 && en.
  - Width is clog2(TICK_MAX).
- The FSM, duty update arithmetic and command latches live in `pwm_ramp_ctrl`.

## Test plan
All scenarios use CLK_FREQ=100, STEP_FREQ=25 (TICK_MAX=4) and DUTY_W=8.
- Up-ramp: from duty 0, command target=10, step=3 → duty 3, 6, 9, 10 at accept+4, +8, +12, +16. `done` pulses once at cycle +16. `busy` is high for the 16 cycles from +1.
- Down-ramp with saturation: from duty 250, command target=0, step=100 → duty 150, 50, 0. No underflow. One `done` pulse.
- Overflow guard and zero step:
  - From duty 250, command target=255, step=200 → duty 255 after one tick.
  - Command with step=0, target=duty+2 → two ticks of +1.
- Abort: during a ramp, assert `abort` on the same cycle as a tick → duty unchanged, state IDLE next edge, no `done`, `cmd_ready`=1.
- Equal target and held valid: command target equal to current duty → `done` 2 cycles after accept. A second command held on `cmd_valid` is accepted on the first IDLE cycle.
- Reset mid-ramp: drop `rst` asynchronously between edges → duty=0 and `busy`=0 immediately. After release, a new command ramps from 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM ramp controller:
//   - state_t          : ramp sequencer states (IDLE, RAMP, DONE)
//   - CLK_FREQ_DEFAULT : default system clock frequency in Hz
//   - tick_max()       : clock cycles per ramp tick
//   - presc_width()    : prescaler counter width for a given tick period
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CLK_FREQ_DEFAULT  = 50_000_000;
    localparam int STEP_FREQ_DEFAULT = 1000;

    // Number of system clock cycles between two ramp ticks.
    function automatic int tick_max(input int clk_freq, input int step_freq);
        return clk_freq / step_freq;
    endfunction

    // Counter width able to hold 0..tm-1; never narrower than one bit.
    function automatic int presc_width(input int tm);
        return (tm <= 2) ? 1 : $clog2(tm);
    endfunction

    localparam int PRESC_W_DEFAULT =
        presc_width(tick_max(CLK_FREQ_DEFAULT, STEP_FREQ_DEFAULT));

endpackage

// File: rtl/tick_gen.sv
// tick_gen
// Free-running prescaler that produces a one-cycle tick every TICK_MAX
// enabled cycles.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear of the count (wins over en)
//   en   : count enable
//   tick : high while count == TICK_MAX-1 and en is high
module tick_gen
    import pwm_pkg::*;
#(
    parameter int TICK_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = presc_width(TICK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             at_last;

    assign at_last = (count_reg == CNT_LAST);

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = at_last ? '0 : count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Decoded from the registered count and the enable only, so the tick
    // is available for the whole final cycle of each period.
    assign tick = at_last && en;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Duty-cycle sequencer: accepts {target, step} over a valid/ready handshake
// and walks the duty output toward the target by one step per ramp tick,
// saturating at the target in either direction.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   cmd_valid  : command offered
//   cmd_ready  : controller idle, command accepted on cmd_valid && cmd_ready
//   cmd_target : requested duty
//   cmd_step   : increment per tick (0 behaves as 1)
//   abort      : stop an active ramp, holding the present duty
//   duty       : registered duty value to the PWM comparator
//   busy       : ramp in progress
//   done       : one-cycle pulse once duty has reached the target
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
    parameter int STEP_FREQ = STEP_FREQ_DEFAULT,
    parameter int DUTY_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [DUTY_W-1:0] cmd_step,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done
);

    localparam int TICK_MAX = tick_max(CLK_FREQ, STEP_FREQ);

    state_t            state_reg,  state_next;
    logic [DUTY_W-1:0] duty_reg,   duty_next;
    logic [DUTY_W-1:0] target_reg, target_next;
    logic [DUTY_W-1:0] step_reg,   step_next;

    logic tick;
    logic presc_clr;
    logic presc_en;

    // The prescaler only runs while ramping. Holding it cleared in every
    // other state gives a fresh 0 count at accept, and an abort clears it on
    // the very edge that leaves RAMP.
    assign presc_en  = (state_reg == RAMP);
    assign presc_clr = (state_reg != RAMP) || abort;

    tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    // Step arithmetic carries one extra bit so neither direction can wrap:
    // an up-step past 2^DUTY_W-1 or a down-step below zero still compares
    // correctly against the target and saturates there.
    logic [DUTY_W:0]   duty_ext;
    logic [DUTY_W:0]   step_ext;
    logic [DUTY_W:0]   target_ext;
    logic [DUTY_W:0]   sum_ext;
    logic [DUTY_W:0]   diff_ext;
    logic [DUTY_W-1:0] up_val;
    logic [DUTY_W-1:0] down_val;
    logic [DUTY_W-1:0] upd_val;

    assign duty_ext   = {1'b0, duty_reg};
    assign step_ext   = {1'b0, step_reg};
    assign target_ext = {1'b0, target_reg};
    assign sum_ext    = duty_ext + step_ext;
    assign diff_ext   = duty_ext - step_ext;

    assign up_val   = (sum_ext > target_ext) ? target_reg : sum_ext[DUTY_W-1:0];
    // diff_ext[DUTY_W] set means the subtraction went below zero.
    assign down_val = (diff_ext[DUTY_W] || (diff_ext < target_ext))
                      ? target_reg : diff_ext[DUTY_W-1:0];
    assign upd_val  = (duty_reg < target_reg) ? up_val : down_val;

    always_comb begin
        state_next  = state_reg;
        duty_next   = duty_reg;
        target_next = target_reg;
        step_next   = step_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    target_next = cmd_target;
                    step_next   = (cmd_step == '0) ? DUTY_W'(1) : cmd_step;
                    state_next  = RAMP;
                end
            end

            RAMP: begin
                if (abort) begin
                    // Abort outranks a coincident tick: duty is left alone.
                    state_next = IDLE;
                end else if (duty_reg == target_reg) begin
                    // Only reachable when the command asked for the duty we
                    // already had; every update path exits on equality.
                    state_next = DONE;
                end else if (tick) begin
                    duty_next = upd_val;
                    if (upd_val == target_reg) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            duty_reg   <= '0;
            target_reg <= '0;
            step_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            duty_reg   <= duty_next;
            target_reg <= target_next;
            step_reg   <= step_next;
        end
    end

    // All outputs decode registered state only.
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg == RAMP);
    assign done      = (state_reg == DONE);
    assign duty      = duty_reg;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

    localparam int DUTY_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_target = '0;
    logic [DUTY_W-1:0] cmd_step = '0;
    logic              abort = 1'b0;
    logic [DUTY_W-1:0] duty;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;
    int cur_duty = 0;

    pwm_ramp_ctrl #(
        .CLK_FREQ  (100),
        .STEP_FREQ (25),
        .DUTY_W    (DUTY_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .abort      (abort),
        .duty       (duty),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int target;
        int step;
        int nupd;       // expected number of duty updates
        int e [4];      // expected duty after each update
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input int t, input int s, input int n,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.target = t; v.step = s; v.nupd = n;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from an IDLE cycle and check every cycle through the
    // return to IDLE. k counts edges after the accept edge.
    task automatic run_cmd(input int vi, input vec_t v);
        int len;
        int idx;
        int exp_duty;
        cmd_valid  = 1'b1;
        cmd_target = DUTY_W'(v.target);
        cmd_step   = DUTY_W'(v.step);
        step();
        cmd_valid  = 1'b0;
        len = (v.nupd == 0) ? 1 : v.nupd * 4;
        for (int k = 0; k <= len + 1; k++) begin
            idx = k / 4;
            if (idx == 0 || v.nupd == 0) exp_duty = cur_duty;
            else exp_duty = v.e[((idx > v.nupd) ? v.nupd : idx) - 1];
            chk($sformatf("v%0d k%0d duty", vi, k), int'(duty), exp_duty);
            chk($sformatf("v%0d k%0d busy", vi, k), int'(busy), (k < len) ? 1 : 0);
            chk($sformatf("v%0d k%0d done", vi, k), int'(done), (k == len) ? 1 : 0);
            chk($sformatf("v%0d k%0d ready", vi, k), int'(cmd_ready), (k == len + 1) ? 1 : 0);
            step();
        end
        cur_duty = (v.nupd == 0) ? cur_duty : v.e[v.nupd - 1];
        $display("cmd %0d: target=%0d step=%0d updates=%0d duty=%0d",
                 vi, v.target, v.step, v.nupd, duty);
    endtask

    initial begin
        vecs[0] = mk( 10,   3, 4,   3,   6,   9, 10);  // up-ramp, last step clipped
        vecs[1] = mk(250, 120, 2, 130, 250,   0,  0);
        vecs[2] = mk(  0, 100, 3, 150,  50,   0,  0);  // down, saturate at 0
        vecs[3] = mk(250, 255, 1, 250,   0,   0,  0);
        vecs[4] = mk(255, 200, 1, 255,   0,   0,  0);  // 450 would overflow 8 bits
        vecs[5] = mk(253,   0, 2, 254, 253,   0,  0);  // step 0 acts as 1, down
        vecs[6] = mk(255,   0, 2, 254, 255,   0,  0);  // step 0, target=duty+2
        vecs[7] = mk(255,   7, 0,   0,   0,   0,  0);  // target already reached

        // Reset state while held in reset.
        #1;
        chk("rst duty", int'(duty), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst ready", int'(cmd_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_cmd(i, vecs[i]);
        end

        // Abort coinciding with a tick: from 255 toward 100, step 10.
        cmd_valid = 1'b1; cmd_target = 8'd100; cmd_step = 8'd10;
        step();                                 // k=0
        cmd_valid = 1'b0;
        repeat (4) step();                      // k=4, first update
        chk("abort pre duty", int'(duty), 245);
        repeat (3) step();                      // k=7, tick pending this cycle
        chk("abort pre busy", int'(busy), 1);
        abort = 1'b1;
        step();                                 // k=8
        chk("abort duty", int'(duty), 245);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort ready", int'(cmd_ready), 1);
        abort = 1'b0;
        step();
        chk("abort post done", int'(done), 0);
        chk("abort post duty", int'(duty), 245);
        $display("abort: duty held at %0d", duty);

        // Equal target, with a second command held on cmd_valid.
        cmd_valid = 1'b1; cmd_target = 8'd245; cmd_step = 8'd1;
        step();                                 // k=0 accept
        cmd_target = 8'd250; cmd_step = 8'd5;
        chk("eq k0 busy", int'(busy), 1);
        step();                                 // k=1
        chk("eq k1 done", int'(done), 1);
        chk("eq k1 duty", int'(duty), 245);
        step();                                 // k=2 IDLE, held valid
        chk("eq k2 ready", int'(cmd_ready), 1);
        chk("eq k2 done", int'(done), 0);
        step();                                 // k=3 second accept taken
        cmd_valid = 1'b0;
        chk("held k3 busy", int'(busy), 1);
        chk("held k3 ready", int'(cmd_ready), 0);
        repeat (3) step();                      // k=6
        chk("held k6 duty", int'(duty), 245);
        step();                                 // k=7
        chk("held k7 duty", int'(duty), 250);
        chk("held k7 done", int'(done), 1);
        step();
        chk("held k8 ready", int'(cmd_ready), 1);
        $display("equal+held: duty=%0d", duty);

        // Reset dropped between edges in the middle of a ramp.
        cmd_valid = 1'b1; cmd_target = 8'd0; cmd_step = 8'd50;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        chk("mid duty", int'(duty), 200);
        chk("mid busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst duty", int'(duty), 0);
        chk("arst busy", int'(busy), 0);
        chk("arst done", int'(done), 0);
        chk("arst ready", int'(cmd_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        $display("reset mid-ramp: duty=%0d busy=%0d", duty, busy);
        cur_duty = 0;
        run_cmd(8, mk(6, 2, 3, 2, 4, 6, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
